s_axil_register_file: RTL
=========================

# s_axil_register_file

AXI4-Lite slave exposing a bank of 16 read/write 32-bit registers at word offsets 0x00–0x3C. It is the responder counterpart of the team's AXI-Lite register master BFM and the DUT that BFM drives. It handles independent AW/W arrival, byte strobes, back-pressure on B and R, and SLVERR for out-of-range addresses. One write and one read may be in flight at once; there is no further outstanding-transaction depth.

## Interface
Parameters:
- S_AXI_DATA_WIDTH, 32, data bus width; must be 32
- S_AXI_ADDR_WIDTH, 32, address bus width; must be ≥ 7

Ports:
- ACLK  in  1  clock, all logic on rising edge
- ARESET  in  1  reset; synchronous, active-low
- AWADDR  in  ADDR_W  write address
- AWVALID  in  1 / AWREADY  out  1  AW handshake
- WDATA  in  DATA_W  write data
- WSTRB  in  DATA_W/8  byte enables
- WVALID  in  1 / WREADY  out  1  W handshake
- BRESP  out  2  write response
- BVALID  out  1 / BREADY  in  1  B handshake
- ARADDR  in  ADDR_W  read address
- ARVALID  in  1 / ARREADY  out  1  AR handshake
- RDATA  out  DATA_W  read data
- RRESP  out  2  read response
- RVALID  out  1 / RREADY  in  1  R handshake

## Operation
- Decode: index = ADDR[5:2]; ADDR[1:0] ignored. Address ≥ 0x40 is out of range: writes are dropped with BRESP=2'b10 (SLVERR); reads return RDATA=0 with RRESP=2'b10. In-range responses are 2'b00 (OKAY).
- Write FSM states:
  - W_INIT: readies 0. Entered on reset; moves to W_IDLE on the first edge with ARESET high.
  - W_IDLE: AWREADY=WREADY=1.
  - W_HAVE_ADDR: AWREADY=0, WREADY=1.
  - W_HAVE_DATA: AWREADY=1, WREADY=0.
  - W_RESP: both readies 0, BVALID=1.
- Transitions: from W_IDLE, both handshakes in the same cycle go to W_RESP; AW alone goes to W_HAVE_ADDR; W alone goes to W_HAVE_DATA. From W_HAVE_ADDR or W_HAVE_DATA, the missing handshake goes to W_RESP. From W_RESP, BVALID&BREADY goes to W_IDLE.
- Commit: the register updates at the edge where the second of AW/W completes. Byte i is written only if WSTRB[i]=1. WSTRB=0 still yields an OKAY response.
- Read FSM states:
  - R_INIT: ARREADY=0.
  - R_IDLE: ARREADY=1.
  - R_DATA: RVALID=1.
- Read transitions: ARVALID in R_IDLE captures RDATA/RRESP and goes to R_DATA. RVALID&RREADY returns to R_IDLE.
- Read and write FSMs run fully independently.

## Timing
- Reset values: AWREADY, WREADY, ARREADY, BVALID and RVALID are 0; BRESP, RRESP and RDATA are 0; all 16 registers are 0.
- Readies rise one cycle after ARESET deasserts (the INIT→IDLE edge).
- Write latency: the handshake completing at edge E commits at E. BVALID is high from E until the B handshake, and AWREADY/WREADY are low during that time.
- Read latency: AR handshake at edge E puts RVALID/RDATA valid after E. ARREADY is low until the R handshake edge, then high in the next cycle. Throughput is therefore one read per 2 cycles with RREADY held high.
- Stability: BRESP is stable while BVALID=1, and RDATA/RRESP are stable while RVALID=1, regardless of concurrent writes.
- Same-edge read and write of one register: the read captures the pre-write value.
- The slave never waits on BREADY or RREADY before asserting BVALID or RVALID.
- ARESET low mid-transaction: at the next edge both FSMs return to INIT, BVALID/RVALID drop without a handshake, and registers clear.

## Structure
- Package axil_pkg holds:
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10
  - NUM_REG=16
  - the write and read FSM state enums
- Sub-module axil_reg_bank holds the 16×32 storage. It provides a byte-enabled synchronous write port and a combinational read port, with synchronous active-low clear.
- The top level contains both FSMs, address decode and the response registers.

## Test plan
- Fill and read back: write values 1..16 to 0x00..0x3C with AW and W in the same cycle, then read all 16. Each read must return 1..16 with RRESP=00, and every BRESP must be 00.
- Skewed write: AW to 0x08 with data 0xA5A5A5A5 given 3 cycles before W. AWREADY drops after the AW handshake, and BVALID rises only after the W handshake. A read of 0x08 returns 0xA5A5A5A5. Repeat with W given before AW.
- Byte strobes: write 0xFFFFFFFF to 0x10, then write 0x12345678 with WSTRB=4'b0011. A read of 0x10 returns 0xFFFF5678.
- Out of range: a write to 0x40 returns BRESP=10 and leaves registers unchanged. A read of 0x44 returns RDATA=0 and RRESP=10.
- Back-pressure: hold RREADY low for 5 cycles after RVALID, and write the same register during that window. RDATA and RRESP stay constant until the handshake. Hold BREADY low for 4 cycles: BVALID stays high, and AWREADY/WREADY stay 0.
- Mid-operation reset: assert ARESET low while BVALID=1 and RVALID=1. Next cycle all outputs are 0. After release, readies return after 1 cycle and reads of 0x00..0x3C return 0.

Source files
------------

// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared response codes, sizes and FSM state types for the AXI-Lite register file
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int         NUM_REG     = 16;
  localparam int         IDX_W       = 4;

  typedef enum logic [2:0] {
    W_INIT,
    W_IDLE,
    W_HAVE_ADDR,
    W_HAVE_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    R_INIT,
    R_IDLE,
    R_DATA
  } rd_state_t;

endpackage

// File: rtl/axil_reg_bank.sv
// rtl/axil_reg_bank.sv - 16-entry register storage, byte-enabled sync write, combinational read
module axil_reg_bank
  import axil_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                i_clk,
  input  logic                i_resetn,
  input  logic                i_we,
  input  logic [IDX_W-1:0]    i_waddr,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_wstrb,
  input  logic [IDX_W-1:0]    i_raddr,
  output logic [DATA_W-1:0]   o_rdata
);

  logic [DATA_W-1:0] r_mem [NUM_REG];

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      for (int i = 0; i < NUM_REG; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (i_wstrb[b]) begin
          r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  // Read port sees the pre-write value on a same-edge read/write.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/s_axil_register_file.sv
// rtl/s_axil_register_file.sv - AXI4-Lite slave with 16 x 32-bit registers, independent write/read FSMs
module s_axil_register_file
  import axil_pkg::*;
#(
  parameter int S_AXI_DATA_WIDTH = 32,
  parameter int S_AXI_ADDR_WIDTH = 32
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [S_AXI_ADDR_WIDTH-1:0]   AWADDR,
  input  logic                          AWVALID,
  output logic                          AWREADY,
  input  logic [S_AXI_DATA_WIDTH-1:0]   WDATA,
  input  logic [S_AXI_DATA_WIDTH/8-1:0] WSTRB,
  input  logic                          WVALID,
  output logic                          WREADY,
  output logic [1:0]                    BRESP,
  output logic                          BVALID,
  input  logic                          BREADY,
  input  logic [S_AXI_ADDR_WIDTH-1:0]   ARADDR,
  input  logic                          ARVALID,
  output logic                          ARREADY,
  output logic [S_AXI_DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]                    RRESP,
  output logic                          RVALID,
  input  logic                          RREADY
);

  localparam int STRB_W = S_AXI_DATA_WIDTH / 8;

  wr_state_t                   r_wstate, w_wnext;
  rd_state_t                   r_rstate, w_rnext;
  logic [S_AXI_ADDR_WIDTH-1:0] r_awaddr;
  logic [S_AXI_DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]           r_wstrb;
  logic [1:0]                  r_bresp;
  logic [S_AXI_DATA_WIDTH-1:0] r_rdata;
  logic [1:0]                  r_rresp;

  logic                        w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [S_AXI_ADDR_WIDTH-1:0] w_waddr_sel;
  logic [S_AXI_DATA_WIDTH-1:0] w_wdata_sel;
  logic [STRB_W-1:0]           w_wstrb_sel;
  logic                        w_wr_in_range, w_rd_in_range;
  logic [S_AXI_DATA_WIDTH-1:0] w_bank_rdata;
  logic                        w_unused;

  assign AWREADY = (r_wstate == W_IDLE) || (r_wstate == W_HAVE_DATA);
  assign WREADY  = (r_wstate == W_IDLE) || (r_wstate == W_HAVE_ADDR);
  assign BVALID  = (r_wstate == W_RESP);
  assign BRESP   = r_bresp;
  assign ARREADY = (r_rstate == R_IDLE);
  assign RVALID  = (r_rstate == R_DATA);
  assign RDATA   = r_rdata;
  assign RRESP   = r_rresp;

  assign w_aw_hs = AWVALID && AWREADY;
  assign w_w_hs  = WVALID && WREADY;
  assign w_ar_hs = ARVALID && ARREADY;

  // Whichever half arrived first was latched; the other comes straight off the bus.
  assign w_waddr_sel   = (r_wstate == W_HAVE_ADDR) ? r_awaddr : AWADDR;
  assign w_wdata_sel   = (r_wstate == W_HAVE_DATA) ? r_wdata  : WDATA;
  assign w_wstrb_sel   = (r_wstate == W_HAVE_DATA) ? r_wstrb  : WSTRB;
  assign w_wr_in_range = ~|w_waddr_sel[S_AXI_ADDR_WIDTH-1:6];
  assign w_rd_in_range = ~|ARADDR[S_AXI_ADDR_WIDTH-1:6];
  assign w_unused      = &{1'b0, w_waddr_sel[1:0], ARADDR[1:0]};

  always_comb begin
    w_wnext  = r_wstate;
    w_commit = 1'b0;
    case (r_wstate)
      W_INIT: w_wnext = W_IDLE;
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) begin
          w_wnext  = W_RESP;
          w_commit = 1'b1;
        end else if (w_aw_hs) begin
          w_wnext = W_HAVE_ADDR;
        end else if (w_w_hs) begin
          w_wnext = W_HAVE_DATA;
        end
      end
      W_HAVE_ADDR: begin
        if (w_w_hs) begin
          w_wnext  = W_RESP;
          w_commit = 1'b1;
        end
      end
      W_HAVE_DATA: begin
        if (w_aw_hs) begin
          w_wnext  = W_RESP;
          w_commit = 1'b1;
        end
      end
      W_RESP: begin
        if (BREADY) w_wnext = W_IDLE;
      end
      default: w_wnext = W_INIT;
    endcase
  end

  always_comb begin
    w_rnext = r_rstate;
    case (r_rstate)
      R_INIT: w_rnext = R_IDLE;
      R_IDLE: begin
        if (w_ar_hs) w_rnext = R_DATA;
      end
      R_DATA: begin
        if (RREADY) w_rnext = R_IDLE;
      end
      default: w_rnext = R_INIT;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESET) begin
      r_wstate <= W_INIT;
      r_rstate <= R_INIT;
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_bresp  <= RESP_OKAY;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else begin
      r_wstate <= w_wnext;
      r_rstate <= w_rnext;
      if (w_aw_hs) r_awaddr <= AWADDR;
      if (w_w_hs) begin
        r_wdata <= WDATA;
        r_wstrb <= WSTRB;
      end
      if (w_commit) r_bresp <= w_wr_in_range ? RESP_OKAY : RESP_SLVERR;
      if (w_ar_hs) begin
        r_rdata <= w_rd_in_range ? w_bank_rdata : '0;
        r_rresp <= w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  axil_reg_bank #(
    .DATA_W (S_AXI_DATA_WIDTH)
  ) u_bank (
    .i_clk    (ACLK),
    .i_resetn (ARESET),
    .i_we     (w_commit && w_wr_in_range),
    .i_waddr  (w_waddr_sel[5:2]),
    .i_wdata  (w_wdata_sel),
    .i_wstrb  (w_wstrb_sel),
    .i_raddr  (ARADDR[5:2]),
    .o_rdata  (w_bank_rdata)
  );

endmodule
